// File: rtl/axi_stream_cache_arbiter_if.sv
// Stream bundle between NUM producers, the arbiter and the cache write port.
// master: arbiter view, slave: producer/cache view.
interface axi_stream_cache_arbiter_if #(
  parameter int NUM   = 4,
  parameter int DSIZE = 64
);
  localparam int IW = $clog2(NUM);

  logic [NUM*DSIZE-1:0] s_tdata;
  logic [NUM-1:0]       s_tvalid;
  logic [NUM-1:0]       s_tlast;
  logic [NUM-1:0]       s_tready;
  logic [DSIZE-1:0]     m_tdata;
  logic                 m_tvalid;
  logic                 m_tlast;
  logic                 m_tready;
  logic [IW-1:0]        m_tid;

  modport master (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast, m_tid
  );

  modport slave (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast, m_tid
  );
endinterface

// File: rtl/axi_stream_cache_arbiter.sv
// Packet round-robin arbiter in front of the stream cache write port.
// Optional STREAM_CACHE_ARB_MAXLEN_EN adds packet truncation at MAX_BEATS.
module axi_stream_cache_arbiter #(
  parameter int NUM       = 4,
  parameter int DSIZE     = 64,
  parameter int MAX_BEATS = 256,
  parameter int FSIZE     = 10
) (
  input  logic                        aclk,
  input  logic                        rst,
  axi_stream_cache_arbiter_if.master  bus,
  input  logic [FSIZE-1:0]            fifo_free,
  output logic                        busy,
  output logic                        trunc_err
);

  localparam int IW = $clog2(NUM);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    gnt_q, gnt_d;
  logic [IW-1:0]    rr_q, rr_d;
  logic [IW-1:0]    pick;
  logic             pick_vld;
  logic             room;
  logic             src_vld;
  logic             src_last;
  logic [DSIZE-1:0] src_data;
  logic             fire;
  logic             trunc_now;

  assign room     = 32'(fifo_free) >= 32'(MAX_BEATS);
  assign src_vld  = bus.s_tvalid[gnt_q];
  assign src_last = bus.s_tlast[gnt_q];
  assign src_data = bus.s_tdata[gnt_q*DSIZE +: DSIZE];
  assign fire     = (state_q == XFER) && src_vld && bus.m_tready;
  assign busy     = (state_q != IDLE);

`ifdef STREAM_CACHE_ARB_MAXLEN_EN
  localparam int CW = $clog2(MAX_BEATS) + 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          trunc_q;

  assign trunc_now = fire && !src_last &&
                     (cnt_q == CW'(MAX_BEATS - 1));
  assign trunc_err = trunc_q;

  // beat count restarts every time a new grant is taken
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) cnt_d = '0;
    else if (fire)       cnt_d = cnt_q + 1'b1;
  end

  // truncation counter and its one-cycle error flag
  always_ff @(posedge aclk) begin
    if (rst) begin
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      trunc_q <= trunc_now;
    end
  end
`else
  assign trunc_now = 1'b0;
  assign trunc_err = 1'b0;
`endif

  // first requester at or after rr_q, wrapping
  always_comb begin
    int j;
    j        = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 0; k < NUM; k++) begin
      j = int'(rr_q) + k;
      if (j >= NUM) j = j - NUM;
      if (!pick_vld && bus.s_tvalid[j]) begin
        pick     = IW'(j);
        pick_vld = 1'b1;
      end
    end
  end

  // output steering from the granted source
  always_comb begin
    bus.s_tready = '0;
    bus.m_tdata  = '0;
    bus.m_tvalid = 1'b0;
    bus.m_tlast  = 1'b0;
    bus.m_tid    = '0;
    if (state_q == XFER) begin
      bus.s_tready[gnt_q] = bus.m_tready;
      bus.m_tdata         = src_data;
      bus.m_tvalid        = src_vld;
      bus.m_tlast         = src_last | trunc_now;
      bus.m_tid           = gnt_q;
    end else if (state_q == DROP) begin
      bus.s_tready[gnt_q] = 1'b1;
    end
  end

  // grant / packet-end state transitions
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (pick_vld && room) begin
          state_d = XFER;
          gnt_d   = pick;
          rr_d    = (pick == IW'(NUM - 1)) ?
                    '0 : pick + 1'b1;
        end
      end
      XFER: begin
        if (fire && src_last) state_d = IDLE;
        else if (trunc_now)   state_d = DROP;
      end
      DROP: begin
        if (src_vld && src_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // arbiter state registers
  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
    end
  end

endmodule

// File: tb/tb_axi_stream_cache_arbiter.sv
// Bench for axi_stream_cache_arbiter: vector table, directed
// sequences and a queue-based random scoreboard.
module tb_axi_stream_cache_arbiter;

`ifdef STREAM_CACHE_ARB_MAXLEN_EN
  localparam int MB = 4;
`else
  localparam int MB = 256;
`endif
  localparam int N = 4;

  logic       clk;
  logic       rst;
  logic [9:0] free;
  logic       busy;
  logic       terr;

  axi_stream_cache_arbiter_if #(.NUM(N), .DSIZE(64)) ifc ();

  axi_stream_cache_arbiter #(
    .NUM(N), .DSIZE(64), .MAX_BEATS(MB), .FSIZE(10)
  ) dut (
    .aclk(clk), .rst(rst), .bus(ifc.master),
    .fifo_free(free), .busy(busy), .trunc_err(terr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [63:0] a,
                     input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  // free code: 0 -> plenty, 1 -> MB-1, 2 -> MB
  typedef struct {
    logic [3:0] v;
    logic       r;
    int         fc;
    logic       eb;
    logic [1:0] et;
    logic [3:0] es;
    logic       em;
  } vec_t;

  typedef struct {
    logic [63:0] d;
    logic        l;
  } beat_t;

  beat_t srcq[N][$];
  int    dgr[$];
  bit    mbusy;
  int    mgnt;
  int    mptr;

  function automatic int fval(input int fc);
    if (fc == 1) return MB - 1;
    if (fc == 2) return MB;
    return 500;
  endfunction

  function automatic bit pending();
    for (int i = 0; i < N; i++)
      if (srcq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(input logic [3:0] v,
                       input logic [3:0] l,
                       input logic r, input int f);
    ifc.s_tvalid = v;
    ifc.s_tlast  = l;
    ifc.m_tready = r;
    free         = 10'(f);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(4'b0, 4'b0, 1'b1, 500);
    @(negedge clk);
    @(negedge clk);
    rst   = 1'b0;
    mbusy = 1'b0;
    mgnt  = 0;
    mptr  = 0;
  endtask

  task automatic add_pkt(input int s, input int p,
                         input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.d = {8'(s), 8'(p), 16'(k), 32'($urandom)};
      b.l = (k == len - 1);
      srcq[s].push_back(b);
    end
  endtask

  // per-cycle scoreboard; DUT grant starts go to dgr
  task automatic run_eng(input int maxc, input bit gaps,
                         input bit rr, input bit rf,
                         output int cyc);
    logic [3:0] v;
    logic       r;
    int         f;
    bit         pb;
    beat_t      fb;
    logic [3:0] es;
    cyc = 0;
    pb  = 1'b0;
    while ((pending() || mbusy) && cyc < maxc) begin
      for (int i = 0; i < N; i++) begin
        v[i] = 1'b0;
        ifc.s_tdata[i*64 +: 64] = '0;
        ifc.s_tlast[i] = 1'b0;
        if (srcq[i].size() != 0 &&
            (!gaps || $urandom_range(0, 3) != 0)) begin
          v[i] = 1'b1;
          ifc.s_tdata[i*64 +: 64] = srcq[i][0].d;
          ifc.s_tlast[i] = srcq[i][0].l;
        end
      end
      r = rr ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rf && $urandom_range(0, 4) == 0)
        f = $urandom_range(0, MB - 1);
      else if (rf)
        f = $urandom_range(MB, 1023);
      else
        f = 500;
      ifc.s_tvalid = v;
      ifc.m_tready = r;
      free = 10'(f);
      #1;
      es = '0;
      if (mbusy) es[mgnt] = r;
      chk("busy", busy, mbusy);
      chk("m_tid", ifc.m_tid, mbusy ? mgnt : 0);
      chk("s_tready", ifc.s_tready, es);
      chk("m_tvalid", ifc.m_tvalid, mbusy && v[mgnt]);
      if (mbusy && v[mgnt]) begin
        chk("m_tdata", ifc.m_tdata, srcq[mgnt][0].d);
        chk("m_tlast", ifc.m_tlast, srcq[mgnt][0].l);
      end
      if (busy && !pb) dgr.push_back(int'(ifc.m_tid));
      pb = busy;
      if (!mbusy) begin
        if (v != 0 && f >= MB) begin
          for (int k = 0; k < N; k++) begin
            if (!mbusy && v[(mptr + k) % N]) begin
              mbusy = 1'b1;
              mgnt  = (mptr + k) % N;
            end
          end
          mptr = (mgnt + 1) % N;
        end
      end else if (v[mgnt] && r) begin
        fb = srcq[mgnt].pop_front();
        if (fb.l) mbusy = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    if (cyc >= maxc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: got %0d cycles want < %0d",
               cyc, maxc);
    end
  endtask

  vec_t tbl[14];
  int   cyc;
  int   exp_ord[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    tbl[0]  = '{4'b0000, 1, 0, 0, 0, 4'b0000, 0};
    tbl[1]  = '{4'b0010, 1, 1, 0, 0, 4'b0000, 0};
    tbl[2]  = '{4'b0010, 1, 1, 0, 0, 4'b0000, 0};
    tbl[3]  = '{4'b0010, 1, 2, 0, 0, 4'b0000, 0};
    tbl[4]  = '{4'b0010, 1, 0, 1, 1, 4'b0010, 1};
    tbl[5]  = '{4'b1001, 1, 0, 0, 0, 4'b0000, 0};
    tbl[6]  = '{4'b1001, 1, 0, 1, 3, 4'b1000, 1};
    tbl[7]  = '{4'b0001, 1, 0, 0, 0, 4'b0000, 0};
    tbl[8]  = '{4'b0001, 1, 0, 1, 0, 4'b0001, 1};
    tbl[9]  = '{4'b0000, 1, 0, 0, 0, 4'b0000, 0};
    tbl[10] = '{4'b0100, 1, 0, 0, 0, 4'b0000, 0};
    tbl[11] = '{4'b0100, 0, 0, 1, 2, 4'b0000, 1};
    tbl[12] = '{4'b0100, 1, 0, 1, 2, 4'b0100, 1};
    tbl[13] = '{4'b0000, 1, 0, 0, 0, 4'b0000, 0};

    ifc.s_tdata = '0;
    do_reset();

    for (int i = 0; i < N; i++)
      ifc.s_tdata[i*64 +: 64] = 64'hA0 + 64'(i);
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].v, 4'b1111, tbl[i].r, fval(tbl[i].fc));
      #1;
      chk($sformatf("v%0d busy", i), busy, tbl[i].eb);
      chk($sformatf("v%0d tid", i), ifc.m_tid, tbl[i].et);
      chk($sformatf("v%0d srdy", i), ifc.s_tready,
          tbl[i].es);
      chk($sformatf("v%0d mvld", i), ifc.m_tvalid,
          tbl[i].em);
      chk($sformatf("v%0d terr", i), terr, 1'b0);
      if (tbl[i].em) begin
        chk($sformatf("v%0d data", i), ifc.m_tdata,
            64'hA0 + 64'(tbl[i].et));
        chk($sformatf("v%0d last", i), ifc.m_tlast, 1'b1);
      end
      @(negedge clk);
    end

    // reset in the middle of a source-2 packet
    drive(4'b0100, 4'b0000, 1'b1, 500);
    #1 chk("rm idle", busy, 1'b0);
    @(negedge clk);
    #1 chk("rm tid2", ifc.m_tid, 2'd2);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rm still busy", busy, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    drive(4'b1010, 4'b1111, 1'b1, 500);
    #1;
    chk("rm busy", busy, 1'b0);
    chk("rm tid", ifc.m_tid, 2'd0);
    chk("rm srdy", ifc.s_tready, 4'b0000);
    chk("rm mvld", ifc.m_tvalid, 1'b0);
    chk("rm mlast", ifc.m_tlast, 1'b0);
    chk("rm terr", terr, 1'b0);
    @(negedge clk);
    #1;
    chk("rm regrant busy", busy, 1'b1);
    chk("rm regrant tid", ifc.m_tid, 2'd1);
    @(negedge clk);

    // all sources, 3-beat packets, strict rotation
    do_reset();
    dgr.delete();
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < N; s++)
        add_pkt(s, p, (MB < 3) ? MB : 3);
    run_eng(200, 1'b0, 1'b0, 1'b0, cyc);
    chk("rot cycles", cyc, 32);
    chk("rot count", dgr.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < dgr.size())
        chk($sformatf("rot order %0d", i), dgr[i],
            exp_ord[i]);

    // random traffic, back-pressure and free-space dips
    for (int rep = 0; rep < 3; rep++) begin
      do_reset();
      for (int p = 0; p < 6; p++)
        for (int s = 0; s < N; s++)
          if ($urandom_range(0, 3) != 0)
            add_pkt(s, p,
                    $urandom_range(1, (MB < 6) ? MB : 6));
      run_eng(8000, 1'b1, 1'b1, 1'b1, cyc);
    end

`ifdef STREAM_CACHE_ARB_MAXLEN_EN
    // 6-beat packet truncated at 4, tail discarded
    do_reset();
    begin
      int b;
      b = 0;
      for (int it = 0; it < 8; it++) begin
        ifc.s_tdata[63:0] = 64'(b);
        drive((b < 6) ? 4'b0001 : 4'b0000,
              {3'b000, b == 5}, 1'b1, 500);
        #1;
        chk($sformatf("ml%0d busy", it), busy,
            it >= 1 && it <= 6);
        chk($sformatf("ml%0d mvld", it), ifc.m_tvalid,
            it >= 1 && it <= 4);
        chk($sformatf("ml%0d terr", it), terr, it == 5);
        chk($sformatf("ml%0d srdy", it), ifc.s_tready[0],
            it >= 1 && it <= 6);
        if (it >= 1 && it <= 4) begin
          chk($sformatf("ml%0d data", it), ifc.m_tdata,
              64'(it - 1));
          chk($sformatf("ml%0d last", it), ifc.m_tlast,
              it == 4);
        end
        if (ifc.s_tready[0] && ifc.s_tvalid[0]) b++;
        @(negedge clk);
      end
      ifc.s_tdata[127:64] = 64'h55;
      drive(4'b0010, 4'b0010, 1'b1, 500);
      @(negedge clk);
      #1;
      chk("ml next busy", busy, 1'b1);
      chk("ml next tid", ifc.m_tid, 2'd1);
      chk("ml next data", ifc.m_tdata, 64'h55);
      @(negedge clk);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_stream_cache_arbiter.md
# axi_stream_cache_arbiter

Packet-level round-robin arbiter that shares a single stream cache (the dual-clock BRAM FIFO stream buffer) write port between NUM AXI-Stream producers in the same clock domain. Grants one source at a time, holds the grant until that source's tlast beat is accepted, and gates new grants on the cache's free space so a granted packet never stalls mid-transfer on a full cache. Sits directly upstream of the stream cache write side and tags each packet with its source index.

## Interface
- NUM, 4: number of requesting streams, 2..8
- DSIZE, 64: tdata width; DSIZE+1 must be ≤72 to fit the cache
- MAX_BEATS, 256: maximum packet length in beats; also the free-space grant threshold
- FSIZE, 10: width of the cache free-space input
- aclk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- s_tdata  in  NUM*DSIZE  source data, source i at [i*DSIZE +: DSIZE]
- s_tvalid  in  NUM  per-source valid
- s_tlast  in  NUM  per-source last
- s_tready  out  NUM  per-source ready
- m_tdata  out  DSIZE  to cache write data
- m_tvalid  out  1  to cache write enable
- m_tlast  out  1  to cache tlast bit
- m_tready  in  1  cache not full
- m_tid  out  $clog2(NUM)  index of the granted source
- fifo_free  in  FSIZE  cache free entries, write-side count
- busy  out  1  high while a grant is held
- trunc_err  out  1  one-cycle pulse on forced truncation (MAXLEN build only)

## Operation
- States: IDLE, XFER, DROP (DROP exists only with the macro).
- IDLE: the request vector is s_tvalid. Grant goes to the first requester at or after rr_ptr, scanning upward with wrap NUM-1 → 0, and only when fifo_free ≥ MAX_BEATS. Register gnt and go to XFER. Set rr_ptr = gnt+1 mod NUM.
- XFER: m_tdata, m_tvalid and m_tlast are combinational muxes of source gnt. s_tready[gnt] = m_tready, and all other s_tready are 0. A beat transfers when m_tvalid && m_tready. When a beat with tlast is accepted, return to IDLE.
- No requests, or insufficient free space: stay in IDLE. All s_tready = 0, m_tvalid = 0.
- Holding s_tvalid on a non-granted source has no effect; that source waits its round-robin turn.
- m_tid = gnt while in XFER, 0 otherwise.
- busy = (state != IDLE).

## Timing
- Reset values: state IDLE, rr_ptr 0, gnt 0, beat counter 0, s_tready 0, m_tvalid 0, m_tlast 0, m_tid 0, busy 0, trunc_err 0.
- Grant latency: a request in IDLE at edge t gives XFER at t+1. The first beat can transfer in the cycle after t+1. There is one bubble cycle per packet.
- Back-to-back: after a tlast at edge t, IDLE evaluates at t+1 and the next grant is registered at t+2.
- Simultaneous requests use rr_ptr order. Example with NUM=4 and rr_ptr=2, requests 0 and 3: grant 3, then 0.
- Single-beat packets (tvalid and tlast together) are legal. Each takes 2 cycles.
- Reset mid-packet returns to IDLE on the next edge. The partial packet in the cache is not recalled; the cache is reset from the same source.
- fifo_free is sampled only in IDLE. A drop below threshold during XFER does not stop the transfer; m_tready throttles it.

## Configuration
- STREAM_CACHE_ARB_MAXLEN_EN defined:
  - A beat counter (width $clog2(MAX_BEATS)+1) counts accepted beats in XFER and clears on entry to XFER.
  - When the accepted beat is number MAX_BEATS without source tlast, m_tlast is forced to 1 on that beat and trunc_err pulses in the next cycle.
  - The state then goes to DROP. In DROP, s_tready[gnt] = 1 and m_tvalid = 0. Beats are discarded until the source's tlast is accepted, then the state returns to IDLE.
- STREAM_CACHE_ARB_MAXLEN_EN undefined:
  - No counter and no DROP state; trunc_err is tied to 0.
  - Packets longer than MAX_BEATS pass through untouched. The free-space guarantee then does not hold.

## Test plan
- Single source 0 sends 5 beats with tlast on beat 5, fifo_free=500, m_tready=1 -> grant 1 cycle after request, 5 beats out, m_tid=0, m_tlast on beat 5, busy low after the last beat.
- Sources 0-3 all request continuously with 3-beat packets -> output order 0,1,2,3,0,…, one idle cycle between packets, no interleaving of beats within a packet.
- fifo_free=255 with MAX_BEATS=256 and source 1 requesting -> no grant, s_tready=0. Raise fifo_free to 256 -> grant 1 cycle later.
- Source 2 is granted while m_tready toggles 1,0,1,0 -> s_tready[2] mirrors m_tready, no beat is lost or duplicated, other s_tready stay 0.
- MAXLEN build, MAX_BEATS=4, source 0 sends 6 beats -> 4 beats out with m_tlast on beat 4, trunc_err pulses once, beats 5-6 are consumed with m_tvalid=0, then the next grant proceeds.
- rst asserted at beat 2 of a 5-beat packet -> all outputs return to their reset values on the next edge. After release, the grant scan restarts from source 0.
